// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_decoder
//  Description : Strips PS/2 Set-2 prefixes (E0, F0, E1 Pause) from received
//                bytes and queues one {brk, ext, code} event per key action
//                in a first-word-fall-through FIFO. Keyboard control replies
//                are routed to a separate pulse port. Receive errors are
//                counted in a saturating counter.
//  Options     : define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeated
//                make events of the most recently pressed key.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ERRCNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_int_i,
  input  logic [7:0]            rx_data_i,
  input  logic [2:0]            rx_err_i,
  output logic                  evt_valid_o,
  output logic [9:0]            evt_data_o,
  input  logic                  evt_pop_i,
  output logic [DEPTH_LOG2:0]   evt_count_o,
  output logic                  ctrl_valid_o,
  output logic [7:0]            ctrl_code_o,
  output logic                  overflow_o,
  output logic [ERRCNT_W-1:0]   err_count_o,
  input  logic                  clr_i
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  localparam logic [7:0] c_E0   = 8'hE0;
  localparam logic [7:0] c_F0   = 8'hF0;
  localparam logic [7:0] c_E1   = 8'hE1;
  localparam logic [2:0] c_SKIP = 3'd7;   // bytes following E1 in a Pause sequence

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_E0   = 3'd1,
    S_F0   = 3'd2,
    S_E0F0 = 3'd3,
    S_E1   = 3'd4
  } state_t;

  // Byte strobe and prefix state
  state_t       state_q;
  logic [2:0]   skip_q;
  logic         rx_int_q;
  logic         strobe;
  logic         rx_bad;

  // Decoded request for the current strobe
  logic         ev_req;
  logic [9:0]   ev_word;
  logic         ctrl_req;

  // Registered decoder outputs, consumed one cycle later
  logic         push_q;
  logic [9:0]   push_word_q;
  logic         ctrl_pend_q;
  logic [7:0]   ctrl_byte_q;
  logic         err_pend_q;

  // Event FIFO
  logic [9:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  full;
  logic                  empty;
  logic                  push_ok;
  logic                  pop_ok;

  // Status outputs
  logic                  ctrl_valid_q;
  logic [7:0]            ctrl_code_q;
  logic                  overflow_q;
  logic [ERRCNT_W-1:0]   err_count_q;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0]   held_key_q;
  logic         held_vld_q;
`endif

  assign strobe = rx_int_i & ~rx_int_q;
  assign rx_bad = (rx_err_i != 3'd0);

  // Decode the strobed byte against the current prefix state
  always_comb begin
    ev_req   = 1'b0;
    ev_word  = {2'b00, rx_data_i};
    ctrl_req = 1'b0;
    if (strobe && !rx_bad) begin
      case (state_q)
        S_IDLE: begin
          case (rx_data_i)
            c_E0, c_F0, c_E1: ;
            8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ctrl_req = 1'b1;
            default: ev_req = 1'b1;
          endcase
        end
        S_E0: begin
          if (rx_data_i != c_F0) begin
            ev_req  = 1'b1;
            ev_word = {2'b01, rx_data_i};
          end
        end
        S_F0: begin
          ev_req  = 1'b1;
          ev_word = {2'b10, rx_data_i};
        end
        S_E0F0: begin
          ev_req  = 1'b1;
          ev_word = {2'b11, rx_data_i};
        end
        S_E1: begin
          if (skip_q == 3'd1) begin
            ev_req  = 1'b1;
            ev_word = {2'b00, c_E1};
          end
        end
        default: ;
      endcase
    end
  end

  // Prefix FSM with registered push / control / error requests
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      skip_q      <= 3'd0;
      rx_int_q    <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= 10'd0;
      ctrl_pend_q <= 1'b0;
      ctrl_byte_q <= 8'h00;
      err_pend_q  <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_key_q  <= 9'd0;
      held_vld_q  <= 1'b0;
`endif
    end else begin
      rx_int_q    <= rx_int_i;
      push_q      <= 1'b0;
      ctrl_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
      push_word_q <= ev_word;

      if (strobe) begin
        if (rx_bad) begin
          state_q    <= S_IDLE;
          err_pend_q <= 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
          held_vld_q <= 1'b0;
`endif
        end else begin
          case (state_q)
            S_IDLE: begin
              if (rx_data_i == c_E0) begin
                state_q <= S_E0;
              end else if (rx_data_i == c_F0) begin
                state_q <= S_F0;
              end else if (rx_data_i == c_E1) begin
                state_q <= S_E1;
                skip_q  <= c_SKIP;
              end
            end
            S_E0:    state_q <= (rx_data_i == c_F0) ? S_E0F0 : S_IDLE;
            S_F0:    state_q <= S_IDLE;
            S_E0F0:  state_q <= S_IDLE;
            S_E1: begin
              skip_q <= skip_q - 3'd1;
              if (skip_q == 3'd1) begin
                state_q <= S_IDLE;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end

      if (ctrl_req) begin
        ctrl_pend_q <= 1'b1;
        ctrl_byte_q <= rx_data_i;
      end

`ifdef PS2_TYPEMATIC_FILTER_EN
      if (ev_req) begin
        if (!ev_word[9]) begin
          // A repeat of the held make is swallowed; a new make takes its place
          if (!(held_vld_q && held_key_q == ev_word[8:0])) begin
            held_key_q <= ev_word[8:0];
            held_vld_q <= 1'b1;
            push_q     <= 1'b1;
          end
        end else begin
          if (held_vld_q && held_key_q == ev_word[8:0]) begin
            held_vld_q <= 1'b0;
          end
          push_q <= 1'b1;
        end
      end
`else
      if (ev_req) begin
        push_q <= 1'b1;
      end
`endif
    end
  end

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign pop_ok  = evt_pop_i & ~empty;
  assign push_ok = push_q & (~full | evt_pop_i);

  // FIFO storage; contents need no reset since the pointers qualify them
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_word_q;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (DEPTH_LOG2+1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_q && !push_ok) begin
        overflow_q <= 1'b1;
      end else if (clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Control reply pulse and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_valid_q <= 1'b0;
      ctrl_code_q  <= 8'h00;
      err_count_q  <= '0;
    end else begin
      ctrl_valid_q <= ctrl_pend_q;
      if (ctrl_pend_q) begin
        ctrl_code_q <= ctrl_byte_q;
      end
      if (err_pend_q) begin
        if (clr_i) begin
          err_count_q <= ERRCNT_W'(1);
        end else if (err_count_q != '1) begin
          err_count_q <= err_count_q + ERRCNT_W'(1);
        end
      end else if (clr_i) begin
        err_count_q <= '0;
      end
    end
  end

  assign evt_valid_o  = ~empty;
  assign evt_data_o   = mem_q[rd_ptr_q];
  assign evt_count_o  = count_q;
  assign ctrl_valid_o = ctrl_valid_q;
  assign ctrl_code_o  = ctrl_code_q;
  assign overflow_o   = overflow_q;
  assign err_count_o  = err_count_q;

endmodule
`default_nettype wire

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Downstream consumer of the PS/2 receive driver. Takes each received byte and its error code, and strips the Set-2 prefixes (E0, F0, the E1 Pause sequence). The result is one key event per key action ({brk, ext, code}), pushed into a first-word-fall-through FIFO that the CPU drains. Keyboard control replies (ACK, BAT, resend, echo, error) go to a separate pulse port and never enter the event FIFO.

Parameters:
DEPTH_LOG2, 4, log2 of event FIFO depth (16 entries)
ERRCNT_W, 8, width of saturating receive-error counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rx_int  in  1  driver receive-done level; a new byte is flagged by its 0->1 transition
rx_data  in  8  received byte, valid while rx_int high
rx_err  in  3  driver error code, 0 = none, valid while rx_int high
evt_valid  out  1  FIFO not empty
evt_data  out  10  FIFO head {brk, ext, code[7:0]}
evt_pop  in  1  consume head; ignored when empty
evt_count  out  DEPTH_LOG2+1  entries held
ctrl_valid  out  1  one-cycle pulse on control reply
ctrl_code  out  8  control byte, held until next ctrl_valid
overflow  out  1  sticky, event dropped because FIFO full
err_count  out  ERRCNT_W  saturating count of bytes with rx_err != 0
clr  in  1  clears overflow and err_count

Behaviour:
- Reset values: evt_valid 0, evt_count 0, ctrl_valid 0, ctrl_code 8'h00, overflow 0, err_count 0, prefix FSM to S_IDLE, internal rx_int history 0.
- Byte strobe: rx_int registered every cycle; strobe = rx_int & ~rx_int_q. Sampling happens at edge k; the push/ctrl output is visible after edge k+1 (latency 1 cycle).
- If strobe and rx_err != 0: discard the byte, FSM to S_IDLE, err_count +1 (saturates at all-ones). No event is produced.
- FSM states: S_IDLE, S_E0, S_F0, S_E0F0, S_E1.
- S_IDLE, on strobe:
  - E0 -> S_E0
  - F0 -> S_F0
  - E1 -> S_E1 with skip counter = 7
  - FA/AA/FE/EE/00/FF -> ctrl_valid pulse, ctrl_code = byte
  - any other byte -> push {0,0,byte}
- S_E0: F0 -> S_E0F0; any other byte -> push {0,1,byte}, S_IDLE.
- S_F0: push {1,0,byte}, S_IDLE.
- S_E0F0: push {1,1,byte}, S_IDLE.
- S_E1: each strobe decrements the skip counter. When it reaches 0, push {0,0,8'hE1} (Pause) and go to S_IDLE. Pause has no break event.
- Prefix bytes received inside a prefix state (e.g. E0 E0) are treated as the code byte; no nesting.
- FIFO:
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - evt_data always shows the head.
  - Pop while empty: no effect.
  - Push while full without a same-cycle pop: event dropped, overflow set.
  - Push while full with a same-cycle pop: push accepted, count unchanged.
  - Push and pop on an empty FIFO: the push wins, count becomes 1.
- clr: clears overflow and err_count in that cycle. An error or overflow occurring in the same cycle takes priority (flag set, counter = 1).
- rst mid-sequence (e.g. after E0): prefix state is lost and FIFO contents are discarded.

Optional Feature:
PS2_TYPEMATIC_FILTER_EN
- Defined: holds the last make key {ext,code} plus a valid bit.
  - A make equal to the held key is dropped (auto-repeat suppressed).
  - A different make replaces the held key and is pushed.
  - A break matching the held key clears the valid bit; all breaks are pushed.
  - Reset and rx_err clear the valid bit.
- Undefined: every make is pushed, repeats included; no extra state.

Test Plan:
- Plain and extended make/break: bytes 1C, F0 1C, E0 75, E0 F0 75 -> events 0x01C, 0x21C, 0x175, 0x375, in order; evt_count 4.
- Control and Pause: byte FA -> ctrl_valid one cycle, ctrl_code=FA, FIFO unchanged. Then E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x0E1, FSM back in S_IDLE (next 1C -> 0x01C).
- Error recovery: E0, then a byte with rx_err=5 -> no event, err_count=1. Then 74 -> event 0x074 (prefix discarded, not 0x174). clr -> err_count 0.
- Overflow: 17 makes with no pops -> evt_count 16, overflow=1, head is the first code. Push while full with a simultaneous pop -> accepted, count stays 16.
- Latency/edge: hold rx_int high for 5 cycles -> exactly one push, evt_valid rises the cycle after the rising edge is sampled. Pop when empty -> evt_count stays 0.
- Filter (macro defined): 1C 1C 1C F0 1C 1C -> events 0x01C, 0x21C, 0x01C. Macro undefined -> 0x01C ×3, 0x21C, 0x01C.
